r22sdf_bitrev_reorder: RTL

Output reorder stage placed directly downstream of the R22SDF FFT pipeline. It accepts FFT bins in bit-reversed order, one per enabled cycle, and emits each frame in natural bin order with frame markers. Ping-pong double buffering keeps streaming continuous at full rate. The added latency is one frame plus a fixed pipeline delay.

---
 rtl/r22sdf_bitrev_reorder_if.sv | 39 +++
 rtl/r22sdf_bitrev_reorder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r22sdf_bitrev_reorder_if.sv
// ---------------------------------------------------------------------------
// r22sdf_bitrev_reorder_if
//   Streaming bus between the R22SDF FFT output and the natural-order reorder
//   stage.
//   Ports (signals carried):
//     din_valid, din_sof        : input bin qualifier / frame start (bitrev 0)
//     din_r, din_i              : input bin, two's complement, bit-reversed order
//     dout_r, dout_i            : output bin, natural order
//     dout_valid                : output bin qualifier
//     dout_sof, dout_eof        : first / last bin of an output frame
//     frame_err                 : pulse when an input frame is aborted
//   Modports:
//     slave  : reorder block view (consumes din_*, produces dout_*)
//     master : upstream/downstream environment view
// ---------------------------------------------------------------------------
interface r22sdf_bitrev_reorder_if #(
    parameter int DATA_W = 16
);
    logic                     din_valid;
    logic                     din_sof;
    logic signed [DATA_W-1:0] din_r;
    logic signed [DATA_W-1:0] din_i;
    logic signed [DATA_W-1:0] dout_r;
    logic signed [DATA_W-1:0] dout_i;
    logic                     dout_valid;
    logic                     dout_sof;
    logic                     dout_eof;
    logic                     frame_err;

    modport slave (
        input  din_valid, din_sof, din_r, din_i,
        output dout_r, dout_i, dout_valid, dout_sof, dout_eof, frame_err
    );

    modport master (
        output din_valid, din_sof, din_r, din_i,
        input  dout_r, dout_i, dout_valid, dout_sof, dout_eof, frame_err
    );
endinterface

// File: rtl/r22sdf_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// r22sdf_bitrev_reorder
//   Converts bit-reversed FFT output bins into natural-order frames using a
//   ping-pong pair of banks (one being filled while the other is read out).
//   Output latency: bin 0 appears 2 enabled cycles after the enabled edge that
//   accepts the last input bin (3 with R22SDF_REORDER_OUTREG_EN defined, which
//   adds one register stage to dout_* and all flags). Data passes bit-exact.
//   Ports:
//     sys_clk  : clock, rising edge
//     sys_nrst : asynchronous active-low reset
//     sys_en   : global clock enable; every register holds while low
//     bus      : r22sdf_bitrev_reorder_if.slave (din_* in, dout_*/frame_err out)
//   Parameters: DATA_W (sample width), FFT_LENGTH (power of 2, >= 4)
// ---------------------------------------------------------------------------
module r22sdf_bitrev_reorder #(
    parameter int DATA_W     = 16,
    parameter int FFT_LENGTH = 4096
) (
    input  logic                   sys_clk,
    input  logic                   sys_nrst,
    input  logic                   sys_en,
    r22sdf_bitrev_reorder_if.slave bus
);
    localparam int            AW   = $clog2(FFT_LENGTH);
    localparam logic [AW-1:0] LAST = AW'(FFT_LENGTH - 1);

    typedef enum logic {W_SYNC, W_FILL} wr_state_t;
    typedef enum logic {R_IDLE, R_RUN}  rd_state_t;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r = '0;
        for (int k = 0; k < AW; k++) r[k] = a[AW-1-k];
        return r;
    endfunction

    // Both banks live in one array; the MSB of the address selects the bank.
    logic [2*DATA_W-1:0] mem_q [2*FFT_LENGTH];
    logic [2*DATA_W-1:0] rdata_p1_q;

    wr_state_t     wr_state_q, wr_state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          err_q, err_d;
    rd_state_t     rd_state_q, rd_state_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          rd_bank_q, rd_bank_d;
    logic          vld_p1_q, vld_p1_d, sof_p1_q, sof_p1_d, eof_p1_q, eof_p1_d;
    logic          vld_p2_q, vld_p2_d, sof_p2_q, sof_p2_d, eof_p2_q, eof_p2_d;
    logic signed [DATA_W-1:0] dout_r_p2_q, dout_r_p2_d, dout_i_p2_q, dout_i_p2_d;

    logic          we, re, launch;
    logic [AW-1:0] waddr;

    // Write side: bit-reversed arrival index -> natural bin address.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        err_d      = err_q;
        we         = 1'b0;
        launch     = 1'b0;
        waddr      = bitrev(wr_cnt_q);
        if (sys_en) begin
            err_d = 1'b0;
            if (bus.din_valid) begin
                case (wr_state_q)
                    W_SYNC: begin
                        if (bus.din_sof) begin
                            we         = 1'b1;
                            waddr      = '0;
                            wr_cnt_d   = AW'(1);
                            wr_state_d = W_FILL;
                        end
                    end
                    default: begin
                        we = 1'b1;
                        if (bus.din_sof && (wr_cnt_q != '0)) begin
                            // Early sof: drop partial frame, restart in place.
                            err_d    = 1'b1;
                            waddr    = '0;
                            wr_cnt_d = AW'(1);
                        end else if (wr_cnt_q == LAST) begin
                            wr_cnt_d  = '0;
                            wr_bank_d = ~wr_bank_q;
                            launch    = 1'b1;
                        end else begin
                            wr_cnt_d = wr_cnt_q + AW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // Read side: sequential readout of the bank that was just filled.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        vld_p1_d   = vld_p1_q;
        sof_p1_d   = sof_p1_q;
        eof_p1_d   = eof_p1_q;
        re         = 1'b0;
        if (sys_en) begin
            vld_p1_d = 1'b0;
            sof_p1_d = 1'b0;
            eof_p1_d = 1'b0;
            case (rd_state_q)
                R_IDLE: begin
                    if (launch) begin
                        rd_state_d = R_RUN;
                        rd_cnt_d   = '0;
                        rd_bank_d  = wr_bank_q;
                    end
                end
                default: begin
                    re       = 1'b1;
                    vld_p1_d = 1'b1;
                    sof_p1_d = (rd_cnt_q == '0);
                    eof_p1_d = (rd_cnt_q == LAST);
                    if (rd_cnt_q == LAST) begin
                        rd_cnt_d = '0;
                        // A launch here is the next frame: chain with no bubble.
                        if (launch) rd_bank_d  = wr_bank_q;
                        else        rd_state_d = R_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + AW'(1);
                    end
                end
            endcase
        end
    end

    // ---- p1: synchronous bank read ----
    always_ff @(posedge sys_clk) begin
        if (we) mem_q[{wr_bank_q, waddr}] <= {bus.din_r, bus.din_i};
        if (re) rdata_p1_q <= mem_q[{rd_bank_q, rd_cnt_q}];
    end

    // ---- p2: output register; data forced to zero when not valid ----
    always_comb begin
        vld_p2_d    = vld_p2_q;
        sof_p2_d    = sof_p2_q;
        eof_p2_d    = eof_p2_q;
        dout_r_p2_d = dout_r_p2_q;
        dout_i_p2_d = dout_i_p2_q;
        if (sys_en) begin
            vld_p2_d    = vld_p1_q;
            sof_p2_d    = vld_p1_q & sof_p1_q;
            eof_p2_d    = vld_p1_q & eof_p1_q;
            dout_r_p2_d = vld_p1_q ? $signed(rdata_p1_q[2*DATA_W-1:DATA_W]) : '0;
            dout_i_p2_d = vld_p1_q ? $signed(rdata_p1_q[DATA_W-1:0]) : '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            wr_state_q  <= W_SYNC;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            err_q       <= 1'b0;
            rd_state_q  <= R_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            vld_p1_q    <= 1'b0;
            sof_p1_q    <= 1'b0;
            eof_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            sof_p2_q    <= 1'b0;
            eof_p2_q    <= 1'b0;
            dout_r_p2_q <= '0;
            dout_i_p2_q <= '0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            err_q       <= err_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            vld_p1_q    <= vld_p1_d;
            sof_p1_q    <= sof_p1_d;
            eof_p1_q    <= eof_p1_d;
            vld_p2_q    <= vld_p2_d;
            sof_p2_q    <= sof_p2_d;
            eof_p2_q    <= eof_p2_d;
            dout_r_p2_q <= dout_r_p2_d;
            dout_i_p2_q <= dout_i_p2_d;
        end
    end

`ifdef R22SDF_REORDER_OUTREG_EN
    // ---- p3: optional extra output register (data and all flags) ----
    logic vld_p3_q, vld_p3_d, sof_p3_q, sof_p3_d, eof_p3_q, eof_p3_d, err_p3_q, err_p3_d;
    logic signed [DATA_W-1:0] dout_r_p3_q, dout_r_p3_d, dout_i_p3_q, dout_i_p3_d;

    always_comb begin
        vld_p3_d    = sys_en ? vld_p2_q    : vld_p3_q;
        sof_p3_d    = sys_en ? sof_p2_q    : sof_p3_q;
        eof_p3_d    = sys_en ? eof_p2_q    : eof_p3_q;
        err_p3_d    = sys_en ? err_q       : err_p3_q;
        dout_r_p3_d = sys_en ? dout_r_p2_q : dout_r_p3_q;
        dout_i_p3_d = sys_en ? dout_i_p2_q : dout_i_p3_q;
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            vld_p3_q    <= 1'b0;
            sof_p3_q    <= 1'b0;
            eof_p3_q    <= 1'b0;
            err_p3_q    <= 1'b0;
            dout_r_p3_q <= '0;
            dout_i_p3_q <= '0;
        end else begin
            vld_p3_q    <= vld_p3_d;
            sof_p3_q    <= sof_p3_d;
            eof_p3_q    <= eof_p3_d;
            err_p3_q    <= err_p3_d;
            dout_r_p3_q <= dout_r_p3_d;
            dout_i_p3_q <= dout_i_p3_d;
        end
    end

    assign bus.dout_valid = vld_p3_q;
    assign bus.dout_sof   = sof_p3_q;
    assign bus.dout_eof   = eof_p3_q;
    assign bus.frame_err  = err_p3_q;
    assign bus.dout_r     = dout_r_p3_q;
    assign bus.dout_i     = dout_i_p3_q;
`else
    assign bus.dout_valid = vld_p2_q;
    assign bus.dout_sof   = sof_p2_q;
    assign bus.dout_eof   = eof_p2_q;
    assign bus.frame_err  = err_q;
    assign bus.dout_r     = dout_r_p2_q;
    assign bus.dout_i     = dout_i_p2_q;
`endif

endmodule
